rsc_encoder: RTL and testbench
==============================

RSC_ENCODER -- requirements
Module: rsc_encoder

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, width of the signed soft output samples.
REQ-002 SHALL have parameter MAP_AMP, default 1024, BPSK magnitude; it must fit in DWIDTH-1 bits.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port i_valid, input, 1, the input bit is valid this cycle.
REQ-006 SHALL have port i_sof, input, 1, first bit of a frame.
REQ-007 SHALL have port i_eof, input, 1, last bit of a frame.
REQ-008 SHALL have port i_data, input, 1, the information bit u.
REQ-009 SHALL have port o_ready, output, 1, the block accepts input this cycle.
REQ-010 SHALL have port o_valid, output, 1, the output symbol pair is valid.
REQ-011 SHALL have ports o_sof, output, 1, and o_eof, output, 1, frame markers aligned with o_valid.
REQ-012 SHALL have port o_tail, output, 1, marking termination symbols.
REQ-013 SHALL have ports o_sys, output, DWIDTH, and o_par, output, DWIDTH, the BPSK-mapped systematic and parity samples, two's complement.

Function
REQ-014 SHALL implement the 8-state RSC code with feedback g0=1+D^2+D^3 and feedforward g1=1+D+D^3; state {s1,s2,s3}, s1 newest.
REQ-015 SHALL compute, per accepted bit: a=u^s2^s3, p=a^s1^s3; next state s1<=a, s2<=s1, s3<=s2.
REQ-016 SHALL map each bit b to +MAP_AMP when b=0 and -MAP_AMP when b=1, for both o_sys (from u) and o_par (from p).
REQ-017 SHALL register all outputs; latency from an accepted input bit to its output symbol is exactly 1 cycle.
REQ-018 SHALL accept a bit only when i_valid and o_ready are both high; an i_valid asserted while o_ready is low is discarded with no state change.
REQ-019 SHALL use an FSM IDLE/DATA/TAIL. IDLE->DATA on an accepted i_sof. DATA->TAIL on an accepted i_eof (termination built in) or DATA->IDLE (termination not built in). TAIL->IDLE after 3 cycles.
REQ-020 SHALL ignore i_valid without i_sof while in IDLE; no output is produced.
REQ-021 SHALL clear the trellis state to 000 on every accepted i_sof; an i_sof during DATA restarts the frame with no tail for the aborted frame.
REQ-022 SHALL treat i_sof and i_eof in the same accepted cycle as a 1-bit frame.
REQ-023 SHALL assert o_sof on the first data symbol, and o_eof on the last emitted symbol of the frame (last tail symbol if terminating, else last data symbol).

Reset
REQ-024 SHALL, while aresetn is low at a clock edge, set the FSM to IDLE, state to 000, o_valid/o_sof/o_eof/o_tail to 0, o_sys/o_par to 0 and o_ready to 1; a reset mid-frame or mid-tail discards the frame.

Configuration
REQ-025 SHALL use macro RSC_ENC_TERMINATION_EN. When defined: 3 tail cycles per frame with u=s2^s3 (forcing a=0), p=s1^s3, o_tail=1, o_valid=1, and o_ready=0 throughout TAIL, leaving final state 000. When undefined: no TAIL state, o_tail constant 0, o_ready constant 1, trellis left unterminated.

Verification
REQ-026 SHALL pass this scenario (termination defined): 1-bit frame u=1 with sof+eof -> data sys=-1024, par=-1024; tail sys=+1024,-1024,-1024, par=-1024,+1024,-1024; o_eof on the 3rd tail symbol; final state 000.
REQ-027 SHALL pass this scenario: impulse frame u=1,0,0,0 -> par=-1024 x4, sys=-1024,+1024,+1024,+1024; tail sys=-1024,+1024,-1024, par=-1024 x3.
REQ-028 SHALL pass this scenario: 8-bit all-zero frame -> 11 symbols, all sys/par=+1024; o_sof on the 1st symbol, o_eof on the 11th, o_tail on the 9th-11th.
REQ-029 SHALL pass this scenario: i_valid driven during TAIL -> o_ready=0, input discarded, tail sequence unchanged.
REQ-030 SHALL pass this scenario: aresetn pulsed low during the 2nd tail cycle -> next cycle all outputs 0, o_ready=1; a following frame encodes from state 000.
REQ-031 SHALL pass this scenario (termination undefined): impulse frame u=1,0,0,0 -> 4 symbols only, o_eof on the 4th, o_tail never asserted.

Source files
------------

// File: rtl/rsc_encoder.sv
// -----------------------------------------------------------------------------
// rsc_encoder
//   8-state recursive systematic convolutional encoder with BPSK mapping.
//   Feedback g0 = 1+D^2+D^3, feedforward g1 = 1+D+D^3, state {s1,s2,s3}
//   (s1 newest). Each accepted information bit yields one registered
//   systematic/parity sample pair one cycle later.
//
//   Optional feature macro: RSC_ENC_TERMINATION_EN
//     defined   : 3 tail symbols per frame drive the trellis back to 000;
//                 o_ready drops for the tail.
//     undefined : frames end on the last data symbol; o_ready is always 1
//                 and o_tail is always 0.
//
// Parameters
//   DWIDTH   width of the signed output samples
//   MAP_AMP  BPSK magnitude (bit 0 -> +MAP_AMP, bit 1 -> -MAP_AMP)
//
// Ports
//   aclk     clock, rising edge
//   aresetn  synchronous active-low reset
//   i_valid  input bit valid
//   i_sof    first bit of a frame
//   i_eof    last bit of a frame
//   i_data   information bit u
//   o_ready  block accepts input this cycle
//   o_valid  output sample pair valid
//   o_sof    first data symbol of a frame
//   o_eof    last emitted symbol of a frame
//   o_tail   termination symbol
//   o_sys    mapped systematic sample
//   o_par    mapped parity sample
// -----------------------------------------------------------------------------
module rsc_encoder #(
  parameter int DWIDTH  = 16,
  parameter int MAP_AMP = 1024
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic                     i_eof,
  input  logic                     i_data,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic                     o_sof,
  output logic                     o_eof,
  output logic                     o_tail,
  output logic signed [DWIDTH-1:0] o_sys,
  output logic signed [DWIDTH-1:0] o_par
);

  localparam logic signed [DWIDTH-1:0] AMP = DWIDTH'(MAP_AMP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [2:0] trel_q, trel_d;   // [2]=s1, [1]=s2, [0]=s3
  logic       accept;
  logic       is_tail;
  logic       u, a, p;
  logic [2:0] cur;
  logic       vld_d, sof_d, eof_d, tail_d;

  function automatic logic signed [DWIDTH-1:0] bpsk(input logic b);
    return b ? -AMP : AMP;
  endfunction

`ifdef RSC_ENC_TERMINATION_EN
  logic [1:0] tcnt_q, tcnt_d;
  assign is_tail = (fsm_q == TAIL);
  assign o_ready = (fsm_q != TAIL);
`else
  assign is_tail = 1'b0;
  assign o_ready = 1'b1;
`endif

  assign accept = i_valid & o_ready;

  always_comb begin
    fsm_d  = fsm_q;
    trel_d = trel_q;
    vld_d  = 1'b0;
    sof_d  = 1'b0;
    eof_d  = 1'b0;
    tail_d = 1'b0;
`ifdef RSC_ENC_TERMINATION_EN
    tcnt_d = tcnt_q;
`endif
    // Tail input u = s2^s3 cancels the feedback so a = 0 and the
    // register flushes to 000 in three steps.
    u   = is_tail ? (trel_q[1] ^ trel_q[0]) : i_data;
    // A new frame always starts from the zero state, even mid-frame.
    cur = (!is_tail && i_sof) ? 3'b000 : trel_q;
    a   = u ^ cur[1] ^ cur[0];
    p   = a ^ cur[2] ^ cur[0];

    if (is_tail) begin
`ifdef RSC_ENC_TERMINATION_EN
      trel_d = {a, cur[2], cur[1]};
      vld_d  = 1'b1;
      tail_d = 1'b1;
      tcnt_d = tcnt_q + 2'd1;
      if (tcnt_q == 2'd2) begin
        eof_d  = 1'b1;
        fsm_d  = IDLE;
        tcnt_d = 2'd0;
      end
`endif
    end else if (accept && (i_sof || fsm_q == DATA)) begin
      trel_d = {a, cur[2], cur[1]};
      vld_d  = 1'b1;
      sof_d  = i_sof;
      fsm_d  = DATA;
      if (i_eof) begin
`ifdef RSC_ENC_TERMINATION_EN
        fsm_d  = TAIL;
        tcnt_d = 2'd0;
`else
        fsm_d  = IDLE;
        eof_d  = 1'b1;
`endif
      end
    end
  end

  // Output stage: one register between accepted bit and emitted symbol
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      fsm_q   <= IDLE;
      trel_q  <= 3'b000;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
      o_tail  <= 1'b0;
      o_sys   <= '0;
      o_par   <= '0;
`ifdef RSC_ENC_TERMINATION_EN
      tcnt_q  <= 2'd0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      trel_q  <= trel_d;
      o_valid <= vld_d;
      o_sof   <= sof_d;
      o_eof   <= eof_d;
      o_tail  <= tail_d;
      if (vld_d) begin
        o_sys <= bpsk(u);
        o_par <= bpsk(p);
      end
`ifdef RSC_ENC_TERMINATION_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rsc_encoder.sv
// -----------------------------------------------------------------------------
// tb_rsc_encoder
//   Directed self-checking bench for rsc_encoder with hand-computed symbol
//   sequences. Expectations follow RSC_ENC_TERMINATION_EN when it is defined
//   for the build.
// -----------------------------------------------------------------------------
module tb_rsc_encoder;

  localparam int P = 1024;
  localparam int N = -1024;
`ifdef RSC_ENC_TERMINATION_EN
  localparam logic DEOF = 1'b0;  // data symbol never carries eof when tails follow
`else
  localparam logic DEOF = 1'b1;
`endif

  logic aclk = 1'b0;
  logic aresetn, i_valid, i_sof, i_eof, i_data;
  logic o_ready, o_valid, o_sof, o_eof, o_tail;
  logic signed [15:0] o_sys, o_par;

  int n_cmp = 0;
  int n_err = 0;

  rsc_encoder #(.DWIDTH(16), .MAP_AMP(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_valid(i_valid), .i_sof(i_sof), .i_eof(i_eof), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_sof(o_sof), .o_eof(o_eof),
    .o_tail(o_tail), .o_sys(o_sys), .o_par(o_par)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Compare flags {valid,sof,eof,tail} and both samples.
  task automatic check_sym(input string tag, input logic v, input logic s,
                           input logic e, input logic t, input int sys, input int par);
    check({tag, ".flags"}, int'({o_valid, o_sof, o_eof, o_tail}), int'({v, s, e, t}));
    check({tag, ".sys"}, int'(o_sys), sys);
    check({tag, ".par"}, int'(o_par), par);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass,
  // return at the next falling edge with that edge's outputs visible.
  task automatic cyc(input logic v, input logic s, input logic e, input logic d);
    i_valid = v; i_sof = s; i_eof = e; i_data = d;
    @(negedge aclk);
  endtask

  initial begin
    aresetn = 1'b0; i_valid = 1'b0; i_sof = 1'b0; i_eof = 1'b0; i_data = 1'b0;
    @(negedge aclk);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst.flags", int'({o_valid, o_sof, o_eof, o_tail}), 0);
    check("rst.sys", int'(o_sys), 0);
    check("rst.par", int'(o_par), 0);
    check("rst.ready", int'(o_ready), 1);
    aresetn = 1'b1;

    // Valid without sof in IDLE is ignored
    cyc(1, 0, 0, 1);
    check("idle_nosof.valid", int'(o_valid), 0);
    cyc(1, 0, 1, 1);
    check("idle_nosof2.valid", int'(o_valid), 0);

    // Impulse frame 1,0,0,0
    cyc(1, 1, 0, 1); check_sym("imp0", 1, 1, 0, 0, N, N);
    cyc(1, 0, 0, 0); check_sym("imp1", 1, 0, 0, 0, P, N);
    cyc(1, 0, 0, 0); check_sym("imp2", 1, 0, 0, 0, P, N);
    cyc(1, 0, 1, 0); check_sym("imp3", 1, 0, DEOF, 0, P, N);
`ifdef RSC_ENC_TERMINATION_EN
    check("imp.ready_tail", int'(o_ready), 0);
    cyc(0, 0, 0, 0); check_sym("imp_t0", 1, 0, 0, 1, N, N);
    cyc(0, 0, 0, 0); check_sym("imp_t1", 1, 0, 0, 1, P, N);
    cyc(0, 0, 0, 0); check_sym("imp_t2", 1, 0, 1, 1, N, N);
`endif
    check("imp.ready_after", int'(o_ready), 1);
    cyc(0, 0, 0, 0);
    check("imp.idle_valid", int'(o_valid), 0);
    check("imp.idle_tail", int'(o_tail), 0);

    // One-bit frame u=1 with valid driven through the tail
    cyc(1, 1, 1, 1); check_sym("one0", 1, 1, DEOF, 0, N, N);
`ifdef RSC_ENC_TERMINATION_EN
    cyc(1, 1, 0, 1); check_sym("one_t0", 1, 0, 0, 1, P, N);
    check("one.ready_t", int'(o_ready), 0);
    cyc(1, 0, 1, 0); check_sym("one_t1", 1, 0, 0, 1, N, P);
    cyc(1, 0, 0, 1); check_sym("one_t2", 1, 0, 1, 1, N, N);
`endif
    cyc(0, 0, 0, 0);
    check("one.idle_valid", int'(o_valid), 0);

    // 8-bit all-zero frame
    for (int i = 0; i < 8; i++) begin
      cyc(1, (i == 0), (i == 7), 0);
      check_sym($sformatf("zero%0d", i), 1, (i == 0), (i == 7) ? DEOF : 1'b0, 0, P, P);
    end
`ifdef RSC_ENC_TERMINATION_EN
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      check_sym($sformatf("zero_t%0d", i), 1, 0, (i == 2), 1, P, P);
    end
`endif
    cyc(0, 0, 0, 0);

    // Mid-frame sof restarts from state 000 (uncleared state would give par N)
    cyc(1, 1, 0, 1); check_sym("rs0", 1, 1, 0, 0, N, N);
    cyc(1, 1, 1, 0); check_sym("rs1", 1, 1, DEOF, 0, P, P);
`ifdef RSC_ENC_TERMINATION_EN
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      check_sym($sformatf("rs_t%0d", i), 1, 0, (i == 2), 1, P, P);
    end
`endif
    cyc(0, 0, 0, 0);

    // Reset in the second tail cycle (mid-frame reset without termination)
    cyc(1, 1, 1, 1); check_sym("rr0", 1, 1, DEOF, 0, N, N);
`ifdef RSC_ENC_TERMINATION_EN
    cyc(0, 0, 0, 0); check_sym("rr_t0", 1, 0, 0, 1, P, N);
`endif
    aresetn = 1'b0;
    cyc(0, 0, 0, 0);
    check_sym("rr.rst", 0, 0, 0, 0, 0, 0);
    check("rr.ready", int'(o_ready), 1);
    aresetn = 1'b1;
    cyc(1, 1, 0, 1); check_sym("post0", 1, 1, 0, 0, N, N);
    cyc(1, 0, 1, 0); check_sym("post1", 1, 0, DEOF, 0, P, N);
`ifdef RSC_ENC_TERMINATION_EN
    cyc(0, 0, 0, 0); check_sym("post_t0", 1, 0, 0, 1, N, P);
    cyc(0, 0, 0, 0); check_sym("post_t1", 1, 0, 0, 1, N, N);
    cyc(0, 0, 0, 0); check_sym("post_t2", 1, 0, 1, 1, P, P);
`endif
    cyc(0, 0, 0, 0);
    check("post.idle_valid", int'(o_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
